// File: rtl/bubble_sort_loader_if.sv
// Stream-in / packed-frame-out bundle between an element source, the loader and the sorter.
// The master side is the element source; the slave side is the loader.
interface bubble_sort_loader_if #(
  parameter int DIM   = 10,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_last;
  logic                       in_ready;
  logic [DIM*WIDTH-1:0]       prand;
  logic                       sort_valid;
  logic [$clog2(DIM+1)-1:0]   frame_len;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, prand, sort_valid, frame_len
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, prand, sort_valid, frame_len
  );
endinterface

// File: rtl/bubble_sort_loader.sv
// Packs a valid/ready element stream into DIM-slot frames for the bubble sorter and
// strobes sort_valid once the sorter's fixed latency has elapsed for each frame.
module bubble_sort_loader #(
  parameter int               DIM   = 10,
  parameter int               WIDTH = 8,
  parameter int               LAT   = 3,
  parameter logic [WIDTH-1:0] PAD   = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  bubble_sort_loader_if.slave   bus
);

  localparam int CW = $clog2(DIM + 1);
  localparam int LW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [CW-1:0]        frame_len_reg, frame_len_next;
  logic [LW-1:0]        lat_cnt_reg, lat_cnt_next;
  logic                 sort_valid_reg, sort_valid_next;
  logic                 armed_reg;
  logic                 xfer;
  logic                 frame_close;
  logic [DIM*WIDTH-1:0] prand_reg;
  logic [DIM*WIDTH-1:0] frame_img;
  logic [WIDTH-1:0]     shadow_reg [DIM];

  // armed_reg keeps in_ready low while reset is held and for the release cycle
  assign bus.in_ready   = armed_reg && (state_reg == S_FILL);
  assign xfer           = bus.in_valid && bus.in_ready;
  assign frame_close    = xfer && ((count_reg == LAST_IDX) || bus.in_last);
  assign bus.prand      = prand_reg;
  assign bus.sort_valid = sort_valid_reg;
  assign bus.frame_len  = frame_len_reg;

  always_ff @(posedge clk) begin
    if (xfer) begin
      shadow_reg[count_reg] <= bus.in_data;
    end
  end

  // Closing image: buffered slots, the element arriving now, then padding.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_slot
      localparam logic [CW-1:0] IDX = CW'(gi);
      assign frame_img[gi*WIDTH +: WIDTH] = (IDX < count_reg)  ? shadow_reg[gi] :
                                            (IDX == count_reg) ? bus.in_data    : PAD;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    frame_len_next  = frame_len_reg;
    lat_cnt_next    = lat_cnt_reg;
    sort_valid_next = 1'b0;
    case (state_reg)
      S_FILL: begin
        if (frame_close) begin
          frame_len_next = count_reg + CW'(1);
          count_next     = '0;
          lat_cnt_next   = LW'(LAT);
          state_next     = S_WAIT;
        end else if (xfer) begin
          count_next = count_reg + CW'(1);
        end
      end
      S_WAIT: begin
        // The pulse is registered, so it is raised one count early to land LAT clocks after prand.
        if (sort_valid_reg) begin
          state_next = S_FILL;
        end else if (lat_cnt_reg == LW'(1)) begin
          sort_valid_next = 1'b1;
          lat_cnt_next    = '0;
        end else begin
          lat_cnt_next = lat_cnt_reg - LW'(1);
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_FILL;
      count_reg      <= '0;
      frame_len_reg  <= '0;
      lat_cnt_reg    <= '0;
      sort_valid_reg <= 1'b0;
      armed_reg      <= 1'b0;
      prand_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      frame_len_reg  <= frame_len_next;
      lat_cnt_reg    <= lat_cnt_next;
      sort_valid_reg <= sort_valid_next;
      armed_reg      <= 1'b1;
      if (frame_close) begin
        prand_reg <= frame_img;
      end
    end
  end

endmodule

// File: doc/bubble_sort_loader.md
Name: bubble_sort_loader

Overview:
- Upstream feeder for the single-cycle bubble sorter. Accepts array elements one per clock over a valid/ready stream and packs them into a DIM*WIDTH vector that drives the sorter's unsorted-array input.
- Holds each packed frame stable until the sorter's fixed pipeline latency has elapsed, then pulses a strobe marking the sorter's sorted-array output as valid.
- Back-pressures the stream while a frame is in flight.

Parameters:
- DIM, 10, number of elements per array
- WIDTH, 8, bits per element
- LAT, 3, sorter latency in clocks from a stable input to a valid sorted output (two input sync registers plus one output register)
- PAD, {WIDTH{1'b1}}, value written into unfilled slots on a short frame

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  stream element
- in_valid  input  1  in_data valid this cycle
- in_last  input  1  marks final element of a frame; qualified by in_valid
- in_ready  output  1  loader accepts in_data this cycle
- prand  output  DIM*WIDTH  packed unsorted array to the sorter; element k occupies bits [k*WIDTH +: WIDTH]
- sort_valid  output  1  one-cycle pulse: the sorter's sorted output is valid for the current frame
- frame_len  output  $clog2(DIM+1)  number of real (non-pad) elements in the current frame

Behaviour:
- Reset (async assert, sync release): state=FILL, count=0, prand=0, sort_valid=0, frame_len=0, in_ready=0 during reset, in_ready=1 on the first clock after release.
- Transfer: occurs when in_valid && in_ready at posedge. The first element of a frame goes to slot 0, then ascending slots.
- State FILL:
  - in_ready=1.
  - Each transfer writes slot[count] into a shadow buffer and increments count. prand is not touched during FILL, so the sorter keeps seeing the previous frame.
  - Frame closes on a transfer where count==DIM-1 or in_last=1.
  - On close: slots count+1..DIM-1 are set to PAD, the shadow buffer is copied to prand on the same edge, frame_len = count+1, count cleared, go to WAIT.
  - in_last on slot DIM-1 is equivalent to a full frame.
  - There is no in_last-only empty frame: in_last without in_valid is ignored.
- State WAIT:
  - in_ready=0, and prand is held constant.
  - A down-counter is loaded with LAT on entry.
  - sort_valid=1 for exactly one cycle, the cycle in which the sorter's output register holds the result for this prand (LAT clocks after prand changed). Then go to FILL.
  - The first element of the next frame can be accepted in the cycle after the sort_valid pulse.
- Throughput: a full frame takes DIM + LAT + 1 clocks, from first accept to ready again.
- in_valid while in_ready=0: data is not consumed; the source must hold it (standard valid/ready). The loader never drops or duplicates elements.
- Reset mid-FILL: the partial frame is discarded and prand goes to 0.
- Reset mid-WAIT: the pending sort_valid is suppressed and never emitted.
- frame_len changes only on frame close; it stays valid alongside sort_valid.
- LAT must be at least 1. Counter width is $clog2(LAT+1).
- DIM=1: every accepted element closes a frame.

Test Plan:
- Reset release, then stream 10 elements 9,8,...,0 with in_valid constant, in_last on the 10th -> in_ready low for exactly LAT+1 cycles after the 10th accept. prand slot0=9 through slot9=0. sort_valid pulses 3 cycles after prand updates, frame_len=10.
- Short frame 5,3,7 with in_last on 7 -> slots 3..9 = 8'hFF, frame_len=3, single sort_valid pulse.
- Random in_valid gaps (50% duty) over 20 back-to-back frames -> every element appears exactly once, in arrival order. sort_valid count = frame count. prand never changes during WAIT.
- in_valid held high during WAIT with data 8'hAA -> not consumed. The 8'hAA element is captured as slot 0 of the next frame.
- Assert rst for 1 cycle mid-FILL after 4 elements, then stream a fresh 10-element frame -> prand contains only the new frame, frame_len=10.
- Assert rst in WAIT one cycle before the expected sort_valid -> no pulse, prand=0, in_ready=1 after release.
